// File: rtl/execute_cond_stage_if.sv
// Decode-to-execute control bundle and the gated execute-stage outputs.
// The master side is the decode stage and datapath; the slave side is execute_cond_stage.
interface execute_cond_stage_if;
  logic       stalle;
  logic       flushe;
  logic       pcsd;
  logic       regwd;
  logic       memwd;
  logic       memtoregd;
  logic       alusrcd;
  logic [1:0] alucontrold;
  logic [1:0] flagwd;
  logic [3:0] condd;
  logic [3:0] aluflags;

  logic       pcsrce;
  logic       regwritee;
  logic       memwritee;
  logic       memtorege;
  logic       alusrce;
  logic [1:0] alucontrole;
  logic       condexe;
  logic [3:0] flagse;

  modport master (
    output stalle, flushe, pcsd, regwd, memwd, memtoregd, alusrcd,
           alucontrold, flagwd, condd, aluflags,
    input  pcsrce, regwritee, memwritee, memtorege, alusrce,
           alucontrole, condexe, flagse
  );

  modport slave (
    input  stalle, flushe, pcsd, regwd, memwd, memtoregd, alusrcd,
           alucontrold, flagwd, condd, aluflags,
    output pcsrce, regwritee, memwritee, memtorege, alusrce,
           alucontrole, condexe, flagse
  );
endinterface

// File: rtl/execute_cond_stage.sv
// Execute-stage control register, architectural NZCV flags and condition check.
// The gated writes depend only on registered state; ALU flags reach them solely through the flag register.
module execute_cond_stage (
  input  logic                 clk,
  input  logic                 reset,
  execute_cond_stage_if.slave  bus
);
  localparam logic [3:0] COND_AL = 4'b1110;

  logic       pcs_e;
  logic       regw_e;
  logic       memw_e;
  logic       memtoreg_e;
  logic       alusrc_e;
  logic [1:0] aluctl_e;
  logic [1:0] flagw_e;
  logic [3:0] cond_e;
  logic [3:0] flags_q;
  logic       condex;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // A bubble is an always-executing no-op so it never suppresses anything downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcs_e      <= 1'b0;
      regw_e     <= 1'b0;
      memw_e     <= 1'b0;
      memtoreg_e <= 1'b0;
      alusrc_e   <= 1'b0;
      aluctl_e   <= 2'b00;
      flagw_e    <= 2'b00;
      cond_e     <= COND_AL;
    end else if (bus.flushe) begin
      pcs_e      <= 1'b0;
      regw_e     <= 1'b0;
      memw_e     <= 1'b0;
      memtoreg_e <= 1'b0;
      alusrc_e   <= 1'b0;
      aluctl_e   <= 2'b00;
      flagw_e    <= 2'b00;
      cond_e     <= COND_AL;
    end else if (!bus.stalle) begin
      pcs_e      <= bus.pcsd;
      regw_e     <= bus.regwd;
      memw_e     <= bus.memwd;
      memtoreg_e <= bus.memtoregd;
      alusrc_e   <= bus.alusrcd;
      aluctl_e   <= bus.alucontrold;
      flagw_e    <= bus.flagwd;
      cond_e     <= bus.condd;
    end
  end

  // Flags follow the instruction leaving E, even when a flush replaces it with a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (!bus.stalle) begin
      if (flagw_e[1] && condex) flags_q[3:2] <= bus.aluflags[3:2];
      if (flagw_e[0] && condex) flags_q[1:0] <= bus.aluflags[1:0];
    end
  end

  always_comb begin
    condex = 1'b0;
    unique case (cond_e)
      4'b0000: condex = flag_z;
      4'b0001: condex = !flag_z;
      4'b0010: condex = flag_c;
      4'b0011: condex = !flag_c;
      4'b0100: condex = flag_n;
      4'b0101: condex = !flag_n;
      4'b0110: condex = flag_v;
      4'b0111: condex = !flag_v;
      4'b1000: condex = flag_c && !flag_z;
      4'b1001: condex = !flag_c || flag_z;
      4'b1010: condex = (flag_n == flag_v);
      4'b1011: condex = (flag_n != flag_v);
      4'b1100: condex = !flag_z && (flag_n == flag_v);
      4'b1101: condex = flag_z || (flag_n != flag_v);
      4'b1110: condex = 1'b1;
      4'b1111: condex = 1'b0;
      default: condex = 1'b0;
    endcase
  end

  assign bus.condexe     = condex;
  assign bus.pcsrce      = pcs_e  & condex;
  assign bus.regwritee   = regw_e & condex;
  assign bus.memwritee   = memw_e & condex;
  assign bus.memtorege   = memtoreg_e;
  assign bus.alusrce     = alusrc_e;
  assign bus.alucontrole = aluctl_e;
  assign bus.flagse      = flags_q;
endmodule

// File: tb/tb_execute_cond_stage.sv
// Directed bench for execute_cond_stage: behavioural model checked every cycle,
// plus literal expectations for the documented scenarios and a short random soak.
module tb_execute_cond_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  execute_cond_stage_if bus ();
  execute_cond_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Model of the execute register contents and flags
  logic       m_pcs, m_regw, m_memw, m_mtr, m_alusrc;
  logic [1:0] m_aluctl, m_flagw;
  logic [3:0] m_cond, m_flags;

  // Conditions come in pairs: odd code is the inverse of the even one below it.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_edge();
    logic pass;
    pass = cond_ok(m_cond, m_flags);
    if (reset) begin
      {m_pcs, m_regw, m_memw, m_mtr, m_alusrc} = '0;
      m_aluctl = 2'b00; m_flagw = 2'b00; m_cond = 4'b1110; m_flags = 4'b0000;
    end else begin
      if (!bus.stalle) begin
        if (m_flagw[1] && pass) m_flags[3:2] = bus.aluflags[3:2];
        if (m_flagw[0] && pass) m_flags[1:0] = bus.aluflags[1:0];
      end
      if (bus.flushe) begin
        {m_pcs, m_regw, m_memw, m_mtr, m_alusrc} = '0;
        m_aluctl = 2'b00; m_flagw = 2'b00; m_cond = 4'b1110;
      end else if (!bus.stalle) begin
        m_pcs = bus.pcsd; m_regw = bus.regwd; m_memw = bus.memwd;
        m_mtr = bus.memtoregd; m_alusrc = bus.alusrcd;
        m_aluctl = bus.alucontrold; m_flagw = bus.flagwd; m_cond = bus.condd;
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic pass;
    pass = cond_ok(m_cond, m_flags);
    chk("model.condexe",     {3'b0, bus.condexe},   {3'b0, pass});
    chk("model.pcsrce",      {3'b0, bus.pcsrce},    {3'b0, m_pcs & pass});
    chk("model.regwritee",   {3'b0, bus.regwritee}, {3'b0, m_regw & pass});
    chk("model.memwritee",   {3'b0, bus.memwritee}, {3'b0, m_memw & pass});
    chk("model.memtorege",   {3'b0, bus.memtorege}, {3'b0, m_mtr});
    chk("model.alusrce",     {3'b0, bus.alusrce},   {3'b0, m_alusrc});
    chk("model.alucontrole", {2'b0, bus.alucontrole}, {2'b0, m_aluctl});
    chk("model.flagse",      bus.flagse,            m_flags);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic pcs, input logic regw, input logic memw,
                       input logic [1:0] flagw, input logic [3:0] cond);
    bus.pcsd = pcs; bus.regwd = regw; bus.memwd = memw;
    bus.memtoregd = 1'b0; bus.alusrcd = 1'b0; bus.alucontrold = 2'b00;
    bus.flagwd = flagw; bus.condd = cond;
  endtask

  task automatic drive_random();
    {bus.pcsd, bus.regwd, bus.memwd, bus.memtoregd, bus.alusrcd} = 5'($urandom);
    bus.alucontrold = 2'($urandom);
    bus.flagwd      = 2'($urandom);
    bus.condd       = 4'($urandom);
    bus.aluflags    = 4'($urandom);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".pcsrce"},    {3'b0, bus.pcsrce},    4'd0);
    chk({tag, ".regwritee"}, {3'b0, bus.regwritee}, 4'd0);
    chk({tag, ".memwritee"}, {3'b0, bus.memwritee}, 4'd0);
    chk({tag, ".memtorege"}, {3'b0, bus.memtorege}, 4'd0);
    chk({tag, ".alusrce"},   {3'b0, bus.alusrce},   4'd0);
    chk({tag, ".alucontrole"}, {2'b0, bus.alucontrole}, 4'd0);
    chk({tag, ".condexe"},   {3'b0, bus.condexe},   4'd1);
  endtask

  // Load a flag-setting AL instruction, then let it write the given flags.
  task automatic set_flags(input logic [3:0] f);
    drive(0, 0, 0, 2'b11, 4'b1110);
    tick();
    bus.aluflags = f;
    drive(0, 0, 0, 2'b00, 4'b1110);
    tick();
  endtask

  initial begin
    bus.stalle = 1'b0; bus.flushe = 1'b0; bus.aluflags = 4'h0;
    drive_random();
    reset = 1'b1;
    repeat (2) begin drive_random(); tick(); end
    chk_bubble("reset");
    chk("reset.flagse", bus.flagse, 4'b0000);
    reset = 1'b0;

    // Full flag write, then EQ consumes Z with no bubble
    drive(0, 0, 0, 2'b11, 4'b1110);
    tick();
    bus.aluflags = 4'b0100;
    drive(0, 1, 0, 2'b00, 4'b0000);
    tick();
    chk("fullwrite.flagse", bus.flagse, 4'b0100);
    chk("fullwrite.regwritee_eq", {3'b0, bus.regwritee}, 4'd1);

    // Partial writes
    set_flags(4'b0110);
    chk("partial.pre", bus.flagse, 4'b0110);
    drive(0, 0, 0, 2'b10, 4'b1110);
    tick();
    bus.aluflags = 4'b1001;
    drive(0, 0, 0, 2'b01, 4'b1110);
    tick();
    chk("partial.nz", bus.flagse, 4'b1010);
    bus.aluflags = 4'b0101;
    drive(0, 0, 0, 2'b00, 4'b1110);
    tick();
    chk("partial.cv", bus.flagse, 4'b1001);

    // Failed condition suppresses writes and flag updates
    drive(0, 0, 0, 2'b11, 4'b1110);
    tick();
    bus.aluflags = 4'b0000;
    drive(1, 1, 1, 2'b11, 4'b0000);
    tick();
    chk("condfail.condexe",   {3'b0, bus.condexe},   4'd0);
    chk("condfail.pcsrce",    {3'b0, bus.pcsrce},    4'd0);
    chk("condfail.regwritee", {3'b0, bus.regwritee}, 4'd0);
    chk("condfail.memwritee", {3'b0, bus.memwritee}, 4'd0);
    bus.aluflags = 4'b1111;
    drive(0, 0, 0, 2'b00, 4'b1110);
    tick();
    chk("condfail.flagse", bus.flagse, 4'b0000);

    // Signed conditions with N=1, V=1, Z=0
    drive(0, 0, 0, 2'b11, 4'b1110);
    tick();
    bus.aluflags = 4'b1001;
    drive(0, 0, 0, 2'b00, 4'b1100); tick();
    chk("signed.gt", {3'b0, bus.condexe}, 4'd1);
    drive(0, 0, 0, 2'b00, 4'b1011); tick();
    chk("signed.lt", {3'b0, bus.condexe}, 4'd0);
    drive(0, 0, 0, 2'b00, 4'b1101); tick();
    chk("signed.le", {3'b0, bus.condexe}, 4'd0);
    drive(0, 0, 0, 2'b00, 4'b1010); tick();
    chk("signed.ge", {3'b0, bus.condexe}, 4'd1);
    drive(0, 0, 0, 2'b00, 4'b1111); tick();
    chk("signed.nv", {3'b0, bus.condexe}, 4'd0);

    // Stall three cycles with a flag-setting store held in E
    drive(0, 0, 1, 2'b11, 4'b1110);
    tick();
    bus.stalle = 1'b1;
    drive(0, 0, 0, 2'b00, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      bus.aluflags = (i % 2 == 0) ? 4'b0110 : 4'b1111;
      tick();
      chk("stall.memwritee", {3'b0, bus.memwritee}, 4'd1);
      chk("stall.flagse", bus.flagse, 4'b1001);
    end
    bus.flushe = 1'b1;
    tick();
    chk_bubble("stallflush");
    chk("stallflush.flagse", bus.flagse, 4'b1001);
    bus.stalle = 1'b0; bus.flushe = 1'b0;

    // Reset while stalled
    drive(1, 1, 1, 2'b11, 4'b1110);
    tick();
    bus.stalle = 1'b1; reset = 1'b1;
    tick();
    chk_bubble("resetstall");
    chk("resetstall.flagse", bus.flagse, 4'b0000);
    bus.stalle = 1'b0; reset = 1'b0;

    // Random soak against the model
    for (int i = 0; i < 400; i++) begin
      drive_random();
      bus.stalle = ($urandom_range(0, 4) == 0);
      bus.flushe = ($urandom_range(0, 6) == 0);
      reset      = ($urandom_range(0, 40) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
